// File: rtl/bus_in_buffer_pkg.sv
// Shared bus defines plus types and defaults for the bus receive buffer.
// Optional feature macro: BUS_IN_BYPASS_EN (zero-latency bypass into an empty buffer).
`ifndef BUS_DEFINES_SVH
`define BUS_DEFINES_SVH
`define DATA_SIZE 8
`define LG_DATA_SIZE 3
`define VALID_PART_NONE 2'b00
`define VALID_PART_LO 2'b01
`define VALID_PART_HI 2'b10
`define VALID_PART_ALL 2'b11
`endif

package bus_in_buffer_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 3;
  localparam int HALF_W    = `DATA_SIZE;
  localparam int WORD_W    = 2 * `DATA_SIZE;

  typedef enum logic [1:0] {
    VP_NONE = `VALID_PART_NONE,
    VP_LO   = `VALID_PART_LO,
    VP_HI   = `VALID_PART_HI,
    VP_ALL  = `VALID_PART_ALL
  } valid_part_e;

  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
    logic              hi_have;
    logic              lo_have;
  } asm_t;

endpackage

// File: rtl/bus_in_buffer_fifo.sv
// bus_word_fifo: small word FIFO with a registered head word that holds its value when empty.
module bus_word_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             nonempty
);

  localparam int PTR_W = CNT_W - 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     head_q, head_d;
  logic             nonempty_q, nonempty_d;
  logic             push_en_s, pop_en_s;

  // Next-state for storage, pointers, occupancy and the registered head word.
  always_comb begin
    push_en_s = push && (count_q < CNT_W'(DEPTH));
    pop_en_s  = pop && (count_q != '0);
    rd_next_s = rd_ptr_q + PTR_W'(1);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;

    if (push_en_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_en_s) begin
      rd_ptr_d = rd_next_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head only moves when it is replaced; an emptied FIFO keeps showing the last word.
    if (pop_en_s) begin
      if (count_q > CNT_W'(1)) begin
        head_d = mem_q[rd_next_s];
      end else if (push_en_s) begin
        head_d = wdata;
      end else begin
        head_d = head_q;
      end
    end else if (push_en_s && (count_q == '0)) begin
      head_d = wdata;
    end else begin
      head_d = head_q;
    end

    nonempty_d = (count_d != '0);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      nonempty_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      nonempty_q <= nonempty_d;
    end
  end

  assign rdata    = head_q;
  assign count    = count_q;
  assign nonempty = nonempty_q;

endmodule

// File: rtl/bus_in_buffer.sv
// Receive side of a PE bus link: merges HI/LO half writes into words and queues them.
// Optional feature macro: BUS_IN_BYPASS_EN (empty buffer + ready consumer sees the word same cycle).
module bus_in_buffer
  import bus_in_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*`DATA_SIZE-1:0] busIn,
  input  logic [1:0]              busValidPart,
  output logic                    busReady,
  output logic [2*`DATA_SIZE-1:0] dataOut,
  output logic                    dataValid,
  input  logic                    dataReady,
  output logic [CNT_W-1:0]        count,
  output logic                    partialPending,
  output logic                    protoErr,
  input  logic                    errClear
);

  asm_t              asm_q, asm_d;
  logic              err_q, err_d;
  valid_part_e       vp_s;
  logic              complete_s, err_set_s, bypass_s, push_s, pop_s;
  logic [WORD_W-1:0] word_s, fifo_dout_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_nonempty_s;

  // Half-word assembly, word completion and protocol-error detection.
  always_comb begin
    vp_s       = valid_part_e'(busValidPart);
    asm_d      = asm_q;
    complete_s = 1'b0;
    word_s     = busIn;
    err_set_s  = 1'b0;
    if ((vp_s != VP_NONE) && !busReady) begin
      err_set_s = 1'b1;
    end else begin
      case (vp_s)
        VP_ALL: begin
          complete_s    = 1'b1;
          word_s        = busIn;
          err_set_s     = asm_q.hi_have | asm_q.lo_have;
          asm_d.hi_have = 1'b0;
          asm_d.lo_have = 1'b0;
        end
        VP_LO: begin
          asm_d.lo = busIn[HALF_W-1:0];
          if (asm_q.lo_have) begin
            err_set_s = 1'b1;
          end else if (asm_q.hi_have) begin
            complete_s    = 1'b1;
            word_s        = {asm_q.hi, busIn[HALF_W-1:0]};
            asm_d.hi_have = 1'b0;
          end else begin
            asm_d.lo_have = 1'b1;
          end
        end
        VP_HI: begin
          asm_d.hi = busIn[WORD_W-1:HALF_W];
          if (asm_q.hi_have) begin
            err_set_s = 1'b1;
          end else if (asm_q.lo_have) begin
            complete_s    = 1'b1;
            word_s        = {busIn[WORD_W-1:HALF_W], asm_q.lo};
            asm_d.lo_have = 1'b0;
          end else begin
            asm_d.hi_have = 1'b1;
          end
        end
        default: asm_d = asm_q;
      endcase
    end
    // A new error wins over a same-cycle clear.
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (errClear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Assembly and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q <= '0;
      err_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      err_q <= err_d;
    end
  end

`ifdef BUS_IN_BYPASS_EN
  assign bypass_s  = complete_s && (fifo_count_s == '0) && dataReady;
  assign dataOut   = bypass_s ? word_s : fifo_dout_s;
  assign dataValid = bypass_s | fifo_nonempty_s;
`else
  assign bypass_s  = 1'b0;
  assign dataOut   = fifo_dout_s;
  assign dataValid = fifo_nonempty_s;
`endif

  assign push_s         = complete_s && !bypass_s;
  assign pop_s          = fifo_nonempty_s && dataReady;
  assign busReady       = (fifo_count_s < CNT_W'(DEPTH));
  assign count          = fifo_count_s;
  assign partialPending = asm_q.hi_have ^ asm_q.lo_have;
  assign protoErr       = err_q;

  bus_word_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .W    (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   (word_s),
    .rdata   (fifo_dout_s),
    .count   (fifo_count_s),
    .nonempty(fifo_nonempty_s)
  );

endmodule

// File: tb/tb_bus_in_buffer.sv
// Self-checking bench for bus_in_buffer: directed scenarios plus random traffic against a queue model.
module tb_bus_in_buffer;

`ifdef BUS_IN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] busIn = 16'h0000;
  logic [1:0]  busValidPart = 2'b00;
  logic        busReady;
  logic [15:0] dataOut;
  logic        dataValid;
  logic        dataReady = 1'b0;
  logic [2:0]  count;
  logic        partialPending;
  logic        protoErr;
  logic        errClear = 1'b0;

  int n_checks = 0;
  int n_fails = 0;

  logic [15:0] q[$];
  bit          has_hi, has_lo, err_m;
  logic [7:0]  hi_m, lo_m;
  logic [15:0] last_head;

  bus_in_buffer dut (
    .clk(clk), .reset(reset), .busIn(busIn), .busValidPart(busValidPart),
    .busReady(busReady), .dataOut(dataOut), .dataValid(dataValid),
    .dataReady(dataReady), .count(count), .partialPending(partialPending),
    .protoErr(protoErr), .errClear(errClear)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    has_hi = 1'b0; has_lo = 1'b0; err_m = 1'b0;
    hi_m = 8'h00; lo_m = 8'h00; last_head = 16'h0000;
  endtask

  // One bus cycle: drive at negedge, check against the model, advance model, pass the posedge.
  task automatic cycle(input logic [1:0] vp, input logic [15:0] bus, input logic rdy, input logic clr);
    int qs;
    bit complete, err_set, byp;
    logic [15:0] word;
    @(negedge clk);
    busValidPart = vp; busIn = bus; dataReady = rdy; errClear = clr;
    #1;
    qs = q.size();
    complete = 1'b0; err_set = 1'b0; word = 16'h0000;
    check_eq("count", 32'(count), 32'(qs));
    check_eq("busReady", 32'(busReady), 32'(qs < 4));
    check_eq("partialPending", 32'(partialPending), 32'(has_hi ^ has_lo));
    check_eq("protoErr", 32'(protoErr), 32'(err_m));
    if (vp != 2'b00 && qs >= 4) begin
      err_set = 1'b1;
    end else if (vp == 2'b11) begin
      complete = 1'b1; word = bus;
      if (has_hi || has_lo) err_set = 1'b1;
      has_hi = 1'b0; has_lo = 1'b0;
    end else if (vp == 2'b01) begin
      if (has_lo) begin lo_m = bus[7:0]; err_set = 1'b1; end
      else if (has_hi) begin complete = 1'b1; word = {hi_m, bus[7:0]}; has_hi = 1'b0; end
      else begin lo_m = bus[7:0]; has_lo = 1'b1; end
    end else if (vp == 2'b10) begin
      if (has_hi) begin hi_m = bus[15:8]; err_set = 1'b1; end
      else if (has_lo) begin complete = 1'b1; word = {bus[15:8], lo_m}; has_lo = 1'b0; end
      else begin hi_m = bus[15:8]; has_hi = 1'b1; end
    end
    byp = BYP && complete && (qs == 0) && rdy;
    check_eq("dataValid", 32'(dataValid), 32'(byp || qs > 0));
    check_eq("dataOut", 32'(dataOut), 32'(byp ? word : (qs > 0 ? q[0] : last_head)));
    if (qs > 0 && rdy) void'(q.pop_front());
    if (complete && !byp) q.push_back(word);
    if (err_set) err_m = 1'b1;
    else if (clr) err_m = 1'b0;
    if (q.size() > 0) last_head = q[0];
    @(posedge clk);
    #1;
    busValidPart = 2'b00; dataReady = 1'b0; errClear = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) cycle(2'b00, 16'h0000, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_busReady", 32'(busReady), 32'd1);
    check_eq("rst_dataValid", 32'(dataValid), 32'd0);
    check_eq("rst_dataOut", 32'(dataOut), 32'd0);
    check_eq("rst_partial", 32'(partialPending), 32'd0);
    check_eq("rst_protoErr", 32'(protoErr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: single full word, one-cycle latency
    cycle(2'b11, 16'hA55A, 1'b0, 1'b0);
    check_eq("t1_dataOut", 32'(dataOut), 32'h0000A55A);
    check_eq("t1_count", 32'(count), 32'd1);
    check_eq("t1_protoErr", 32'(protoErr), 32'd0);
    drain();

    // 2: HI, two idle cycles, then LO
    cycle(2'b10, 16'h12FF, 1'b0, 1'b0);
    check_eq("t2_pending", 32'(partialPending), 32'd1);
    cycle(2'b00, 16'h0000, 1'b0, 1'b0);
    cycle(2'b00, 16'h0000, 1'b0, 1'b0);
    cycle(2'b01, 16'hEE34, 1'b0, 1'b0);
    check_eq("t2_dataOut", 32'(dataOut), 32'h00001234);
    check_eq("t2_pending_clr", 32'(partialPending), 32'd0);
    drain();

    // 3: fill, dropped write on full, drain in order, clear error
    for (int i = 0; i < 4; i++) cycle(2'b11, 16'h1000 + 16'(i), 1'b0, 1'b0);
    check_eq("t3_full_ready", 32'(busReady), 32'd0);
    cycle(2'b11, 16'hDEAD, 1'b0, 1'b0);
    check_eq("t3_drop_err", 32'(protoErr), 32'd1);
    check_eq("t3_drop_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle(2'b00, 16'h0000, 1'b1, 1'b0);
    check_eq("t3_ready_again", 32'(busReady), 32'd1);
    cycle(2'b00, 16'h0000, 1'b0, 1'b1);
    check_eq("t3_err_clear", 32'(protoErr), 32'd0);

    // 4: simultaneous push/pop at count 2, then a stream across pointer wrap
    cycle(2'b11, 16'h2001, 1'b0, 1'b0);
    cycle(2'b11, 16'h2002, 1'b0, 1'b0);
    cycle(2'b11, 16'h2003, 1'b1, 1'b0);
    check_eq("t4_count_same", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) cycle(2'b11, 16'h3000 + 16'(i), 1'b1, 1'b0);
    drain();

    // 5: repeated LO then HI; ALL during pending half
    cycle(2'b01, 16'hFF11, 1'b0, 1'b0);
    cycle(2'b01, 16'hFF22, 1'b0, 1'b0);
    cycle(2'b10, 16'h33FF, 1'b0, 1'b0);
    check_eq("t5_err", 32'(protoErr), 32'd1);
    check_eq("t5_count", 32'(count), 32'd1);
    check_eq("t5_word", 32'(dataOut), 32'h00003322);
    cycle(2'b01, 16'h0044, 1'b1, 1'b1);
    cycle(2'b11, 16'h5566, 1'b0, 1'b0);
    check_eq("t5_all_err", 32'(protoErr), 32'd1);
    check_eq("t5_all_pending", 32'(partialPending), 32'd0);
    drain();
    cycle(2'b00, 16'h0000, 1'b0, 1'b1);

    // 6: async reset mid-assembly with three queued words
    for (int i = 0; i < 3; i++) cycle(2'b11, 16'h4000 + 16'(i), 1'b0, 1'b0);
    cycle(2'b10, 16'h77FF, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_count", 32'(count), 32'd0);
    check_eq("t6_dataValid", 32'(dataValid), 32'd0);
    check_eq("t6_pending", 32'(partialPending), 32'd0);
    check_eq("t6_dataOut", 32'(dataOut), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

`ifdef BUS_IN_BYPASS_EN
    cycle(2'b11, 16'hBEEF, 1'b1, 1'b0);
    check_eq("byp_count", 32'(count), 32'd0);
`endif

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      cycle(2'($urandom_range(0, 3)), 16'($urandom()), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
